ifu_fetch_queue: RTL

Parametrised next-generation instruction fetch unit for the pipelined MIPS core. Holds the fetch PC and issues in-order requests to instruction memory through a valid/ready handshake. Buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode. Supports redirects (branch/jump/exception) that flush the queue and discard stale in-flight responses.

---
 rtl/ifu_fetch_queue_pkg.sv | 27 ++
 rtl/ifu_sync_fifo.sv | 70 +++++++
 rtl/ifu_fetch_queue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_queue_pkg.sv
// ============================================================================
// Module      : ifu_fetch_queue_pkg
// Description : Shared constants and helpers for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_queue_pkg;

    localparam int unsigned  c_pc_inc           = 4;
    localparam logic [31:0]  c_reset_pc_default = 32'h0000_3000;
    localparam int unsigned  c_err_w            = 1;

    // Exception cause codes raised by fetch (AdEL = address error on load/fetch)
    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4
    } exc_code_e;

    // Queue entry layout is {pc, instr, err}
    function automatic int unsigned entry_width(int unsigned addr_w, int unsigned data_w);
        return addr_w + data_w + c_err_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_sync_fifo.sv
// ============================================================================
// Module      : ifu_sync_fifo
// Description : Synchronous FIFO with flush; head is read straight from storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_sync_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + (c_ptr_w+1)'(w_do_push) - (c_ptr_w+1)'(w_do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
// ============================================================================
// Module      : ifu_fetch_queue
// Description : In-order instruction fetch with credit-limited requests, a
//               decode-facing queue and redirect flush. Optional alignment
//               check enabled by defining IFU_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = c_reset_pc_default
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_err
);

    localparam int unsigned       c_entry_w  = entry_width(ADDR_W, DATA_W);
    localparam int unsigned       c_cnt_w    = $clog2(MAX_OUT + 1);
    localparam int unsigned       c_fcnt_w   = $clog2(DEPTH) + 1;
    localparam int unsigned       c_sum_w    = c_fcnt_w + c_cnt_w;
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_inc      = ADDR_W'(c_pc_inc);

    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_rsp_pc;
    logic [c_cnt_w-1:0]   r_out_cnt;
    logic [c_cnt_w-1:0]   r_drop_cnt;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_fcnt_w-1:0]  w_fifo_count;
    logic [c_entry_w-1:0] w_head;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_sum_w-1:0]   w_total;
    logic                 w_has_credit;
    logic                 w_accept;
    logic                 w_rsp_push;
    logic                 w_local_push;
    logic                 w_fetch_ok;
    logic                 w_rsp_err;
    logic                 w_pop;

    assign w_total      = c_sum_w'(w_fifo_count) + c_sum_w'(r_out_cnt);
    assign w_has_credit = !w_fifo_full && (r_out_cnt < c_cnt_w'(MAX_OUT)) && (w_total < c_sum_w'(DEPTH));

    assign req_valid    = Reset && !redirect_valid && w_fetch_ok && w_has_credit;
    assign req_addr     = r_fetch_pc;
    assign w_accept     = req_valid && req_ready;
    assign w_rsp_push   = rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop        = out_valid && out_ready && !redirect_valid;

`ifdef IFU_ALIGN_CHECK_EN
    logic r_halted;
    logic w_misalign;

    assign w_misalign   = (r_fetch_pc[1:0] != 2'b00);
    assign w_fetch_ok   = !w_misalign;
    assign w_rsp_err    = (r_rsp_pc[1:0] != 2'b00);
    // The error entry waits for every older response so the queue stays in program order
    assign w_local_push = w_misalign && !r_halted && !redirect_valid && (r_out_cnt == '0) && !w_fifo_full;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_local_push) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_fetch_ok   = 1'b1;
    assign w_rsp_err    = 1'b0;
    assign w_local_push = 1'b0;
`endif

    assign w_push_data = w_local_push ? {r_fetch_pc, {DATA_W{1'b0}}, 1'b1}
                                      : {r_rsp_pc, rsp_data, w_rsp_err};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_fetch_pc <= c_reset_pc;
            r_rsp_pc   <= c_reset_pc;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + c_cnt_w'(w_accept) - c_cnt_w'(rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                // Everything still in flight after this cycle belongs to the old stream
                r_drop_cnt <= r_out_cnt - c_cnt_w'(rsp_valid);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + c_inc;
                end
                if (w_rsp_push) begin
                    r_rsp_pc <= r_rsp_pc + c_inc;
                end
                if (rsp_valid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
                end
            end
        end
    end

    ifu_sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (w_rsp_push || w_local_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count),
        .head_data (w_head)
    );

    assign out_valid = !w_fifo_empty;
    assign out_pc    = w_head[c_entry_w-1 -: ADDR_W];
    assign out_instr = w_head[DATA_W:1];
    assign out_err   = w_head[0];

endmodule

`default_nettype wire
